// File: rtl/mem_port_arbiter_if.sv
// Bundle of the two cache requester ports and the single-beat memory port
// shared by mem_port_arbiter. The arbiter connects through the slave modport.
interface mem_port_arbiter_if #(
  parameter int AWIDTH = 9,
  parameter int DWIDTH = 8,
  parameter int BEATS  = 4
);
  localparam int LWIDTH = DWIDTH * BEATS;

  // Requester 0 (I-cache) and requester 1 (D-cache)
  logic              rd_0;
  logic              rd_1;
  logic              wr_0;
  logic              wr_1;
  logic [AWIDTH-1:0] addr_0;
  logic [AWIDTH-1:0] addr_1;
  logic [LWIDTH-1:0] wline_0;
  logic [LWIDTH-1:0] wline_1;
  logic [LWIDTH-1:0] rline_0;
  logic [LWIDTH-1:0] rline_1;
  logic              done_0;
  logic              done_1;
  logic              grant_0;
  logic              grant_1;

  // Memory beat port
  logic [AWIDTH-1:0] mem_addr;
  logic              mem_rd;
  logic              mem_wr;
  logic [DWIDTH-1:0] mem_wbyte;
  logic [DWIDTH-1:0] mem_rbyte;
  logic              mem_ready;
  logic              mem_rvalid;

  modport slave (
    input  rd_0, rd_1, wr_0, wr_1, addr_0, addr_1, wline_0, wline_1,
    input  mem_rbyte, mem_ready, mem_rvalid,
    output rline_0, rline_1, done_0, done_1, grant_0, grant_1,
    output mem_addr, mem_rd, mem_wr, mem_wbyte
  );

  modport master (
    output rd_0, rd_1, wr_0, wr_1, addr_0, addr_1, wline_0, wline_1,
    output mem_rbyte, mem_ready, mem_rvalid,
    input  rline_0, rline_1, done_0, done_1, grant_0, grant_1,
    input  mem_addr, mem_rd, mem_wr, mem_wbyte
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter that turns whole-line read/writeback requests from two
// caches into single-beat commands on one memory port, assembling read lines.
module mem_port_arbiter #(
  parameter int AWIDTH = 9,
  parameter int DWIDTH = 8,
  parameter int BEATS  = 4
) (
  input  logic               clock,
  input  logic               reset_n,
  mem_port_arbiter_if.slave  bus
);

  localparam int BW = $clog2(BEATS);
  localparam logic [BW-1:0] LAST_BEAT = BW'(BEATS - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    RWAIT = 2'd2,
    DONE  = 2'd3
  } state_e;

  typedef logic [BEATS-1:0][DWIDTH-1:0] line_t;

  state_e                 state_q, state_d;
  logic [BW-1:0]          beat_q, beat_d;
  logic                   owner_q, owner_d;
  logic                   last_grant_q, last_grant_d;
  logic                   op_wr_q, op_wr_d;
  logic [AWIDTH-BW-1:0]   tag_q, tag_d;
  line_t                  line_q, line_d;
  line_t                  rline_0_q, rline_0_d;
  line_t                  rline_1_q, rline_1_d;

  logic                   req_0;
  logic                   req_1;
  logic                   pick;
  logic                   issue;

  // The in-line offset bits of the request address select nothing: bursts
  // always start at beat 0 of the line.
  logic unused_addr_bits;
  assign unused_addr_bits = ^{bus.addr_0[BW-1:0], bus.addr_1[BW-1:0]};

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= IDLE;
      beat_q       <= '0;
      owner_q      <= 1'b0;
      last_grant_q <= 1'b1;
      op_wr_q      <= 1'b0;
      tag_q        <= '0;
      // NOTE: the line buffers are reset too, because they drive rline and
      // mem_wbyte, which must read as zero while reset is held.
      line_q       <= '0;
      rline_0_q    <= '0;
      rline_1_q    <= '0;
    end else begin
      // NOTE: state registers update with <= so every register samples the
      // pre-edge values computed by the combinational block.
      state_q      <= state_d;
      beat_q       <= beat_d;
      owner_q      <= owner_d;
      last_grant_q <= last_grant_d;
      op_wr_q      <= op_wr_d;
      tag_q        <= tag_d;
      line_q       <= line_d;
      rline_0_q    <= rline_0_d;
      rline_1_q    <= rline_1_d;
    end
  end

  always_comb begin
    // NOTE: every variable gets its hold value first so no path through the
    // case below can leave one unassigned and infer a latch.
    state_d      = state_q;
    beat_d       = beat_q;
    owner_d      = owner_q;
    last_grant_d = last_grant_q;
    op_wr_d      = op_wr_q;
    tag_d        = tag_q;
    line_d       = line_q;
    rline_0_d    = rline_0_q;
    rline_1_d    = rline_1_q;
    issue        = 1'b0;

    req_0 = bus.rd_0 | bus.wr_0;
    req_1 = bus.rd_1 | bus.wr_1;
    // On contention the requester that was not served last wins.
    pick  = (req_0 && req_1) ? ~last_grant_q : req_1;

    unique case (state_q)
      IDLE: begin
        if (req_0 || req_1) begin
          owner_d      = pick;
          last_grant_d = pick;
          op_wr_d      = pick ? bus.wr_1 : bus.wr_0;
          tag_d        = pick ? bus.addr_1[AWIDTH-1:BW] : bus.addr_0[AWIDTH-1:BW];
          line_d       = pick ? bus.wline_1 : bus.wline_0;
          beat_d       = '0;
          state_d      = ISSUE;
        end
      end

      ISSUE: begin
        if (bus.mem_ready) begin
          issue = 1'b1;
          if (op_wr_q) begin
            beat_d  = beat_q + BW'(1);
            state_d = (beat_q == LAST_BEAT) ? DONE : ISSUE;
          end else begin
            state_d = RWAIT;
          end
        end
      end

      RWAIT: begin
        if (bus.mem_rvalid) begin
          line_d[beat_q] = bus.mem_rbyte;
          beat_d         = beat_q + BW'(1);
          if (beat_q == LAST_BEAT) begin
            state_d = DONE;
            // Publish the finished line so it is valid alongside done.
            if (owner_q) rline_1_d = line_d;
            else         rline_0_d = line_d;
          end else begin
            state_d = ISSUE;
          end
        end
      end

      DONE: begin
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Beat address keeps the line tag and replaces the offset with the beat.
  assign bus.mem_addr  = {tag_q, beat_q};
  assign bus.mem_rd    = issue & ~op_wr_q;
  assign bus.mem_wr    = issue &  op_wr_q;
  assign bus.mem_wbyte = line_q[beat_q];

  assign bus.grant_0   = (state_q != IDLE) & ~owner_q;
  assign bus.grant_1   = (state_q != IDLE) &  owner_q;
  assign bus.done_0    = (state_q == DONE) & ~owner_q;
  assign bus.done_1    = (state_q == DONE) &  owner_q;

  assign bus.rline_0   = rline_0_q;
  assign bus.rline_1   = rline_1_q;

endmodule

// File: doc/mem_port_arbiter.md
MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

Interface
REQ-001 SHALL have parameter AWIDTH, default 9, address width of the memory and requester ports.
REQ-002 SHALL have parameter DWIDTH, default 8, width of one memory beat.
REQ-003 SHALL have parameter BEATS, default 4, beats per cache-line burst; the line width is DWIDTH*BEATS.
REQ-004 SHALL have port clock, input, 1, rising-edge clock.
REQ-005 SHALL have port reset_n, input, 1, asynchronous active-low reset.
REQ-006 SHALL have ports rd_0 and rd_1, input, 1, line-read request from requester 0 (I-cache) or 1 (D-cache), held until done.
REQ-007 SHALL have ports wr_0 and wr_1, input, 1, line-writeback request, held until done.
REQ-008 SHALL have ports addr_0 and addr_1, input, AWIDTH, line address; the low 2 bits are ignored.
REQ-009 SHALL have ports wline_0 and wline_1, input, DWIDTH*BEATS, writeback line with byte 0 in bits [7:0].
REQ-010 SHALL have ports rline_0 and rline_1, output, DWIDTH*BEATS, assembled read line.
REQ-011 SHALL have ports done_0 and done_1, output, 1, one-cycle burst-complete pulse.
REQ-012 SHALL have ports grant_0 and grant_1, output, 1, high while the burst for that requester is in progress.
REQ-013 SHALL have port mem_addr, output, AWIDTH, beat address to memory.
REQ-014 SHALL have ports mem_rd and mem_wr, output, 1, one-cycle beat command strobes.
REQ-015 SHALL have port mem_wbyte, output, DWIDTH, write beat data.
REQ-016 SHALL have port mem_rbyte, input, DWIDTH, read beat data.
REQ-017 SHALL have port mem_ready, input, 1, memory can accept a command this cycle.
REQ-018 SHALL have port mem_rvalid, input, 1, mem_rbyte is valid this cycle.

Function
REQ-019 SHALL implement the FSM IDLE -> ISSUE -> (RWAIT) -> DONE -> IDLE, with all outputs registered or decoded directly from state registers.
REQ-020 In IDLE, the block SHALL arbitrate round-robin between pending requesters (rd_i|wr_i): on contention the requester not granted last wins; last_grant resets to 1, so requester 0 wins the first contention.
REQ-021 On grant, the block SHALL latch op, base = {addr_i[AWIDTH-1:2], 2'b00} and wline_i, clear the beat counter, and enter ISSUE.
REQ-022 If rd_i and wr_i are both high for the same requester, the block SHALL perform the write.
REQ-023 In ISSUE with mem_ready high, the block SHALL drive for exactly one cycle mem_addr = base + beat and either mem_wr with mem_wbyte = line byte[beat], or mem_rd.
- mem_ready low: stay in ISSUE, strobes low.
REQ-024 For a write beat, the block SHALL increment beat on issue; the last beat (beat == BEATS-1) goes to DONE, otherwise it stays in ISSUE, so back-to-back strobes are possible.
REQ-025 For a read beat, the block SHALL go to RWAIT; on mem_rvalid it captures mem_rbyte into line byte[beat] and increments beat.
- Last beat: go to DONE.
- Otherwise: return to ISSUE.
- mem_rvalid in any state other than RWAIT is ignored.
REQ-026 In DONE, the block SHALL pulse done_i for one cycle, update rline_i (read only), and return to IDLE.
- rline_i holds its value until the next read completion for that requester.
- The other requester's rline is unchanged.
REQ-027 Requester inputs SHALL be ignored during DONE, and a request still high in the following IDLE SHALL be treated as a new request.
REQ-028 A requester that deasserts its request mid-burst SHALL NOT abort the burst, and done_i SHALL still pulse.
REQ-029 Beat address arithmetic SHALL be AWIDTH bits, with the low two bits equal to beat and no carry into the tag/index bits.
REQ-030 mem_rd and mem_wr SHALL never be high in the same cycle, and SHALL both be low outside ISSUE-issue cycles.
REQ-031 grant_i SHALL be high from the ISSUE entry through DONE for the granted requester only.

Reset
REQ-032 Asserting reset_n low SHALL immediately force the state to IDLE, beat to 0 and last_grant to 1.
REQ-033 While reset_n is low, all outputs SHALL be 0, including rline_0/1, mem_addr and mem_wbyte.
REQ-034 Reset asserted mid-burst SHALL abandon the burst with no done pulse; requesters reissue after reset.

Verification
REQ-035 Write, with mem_ready held high: wr_0=1, addr_0=9'h1A7, wline_0=32'hDDCCBBAA.
- mem_wr is high for 4 consecutive cycles with mem_addr 1A4,1A5,1A6,1A7 and mem_wbyte AA,BB,CC,DD.
- done_0 is high 5 clocks after the sampling edge.
REQ-036 Read: rd_1=1, addr_1=9'h040, memory returns mem_rvalid 2 cycles after each mem_rd with bytes 11,22,33,44.
- rline_1 = 32'h44332211 and done_1 pulses once.
- rline_0 is unchanged.
REQ-037 Contention: rd_0 and rd_1 are raised in the same cycle and held after reset.
- Bursts are granted in the order 0, 1, 0, 1.
- Each grant is preceded by the other requester's done pulse.
REQ-038 Stall: mem_ready is low for 3 cycles during beat 2 of a write.
- No strobe occurs while mem_ready is low.
- The beat is issued on the first ready cycle with the correct address.
REQ-039 Reset mid-read (after beat 1): all outputs return to 0, done_0 never pulses, and a reissued request completes normally.
REQ-040 rd_0 and wr_0 are both high: a write burst occurs and mem_rd stays 0 throughout.
